// File: rtl/arp_tx_sched_if.sv
// Frame channel between arp_tx_sched (master) and the ARP frame transmitter (slave).
interface arp_tx_sched_if;
    logic        m_frame_valid;
    logic        m_frame_ready;
    logic [47:0] m_eth_dest_mac;
    logic [47:0] m_eth_src_mac;
    logic [15:0] m_eth_type;
    logic [15:0] m_arp_htype;
    logic [15:0] m_arp_ptype;
    logic [15:0] m_arp_oper;
    logic [47:0] m_arp_sha;
    logic [31:0] m_arp_spa;
    logic [47:0] m_arp_tha;
    logic [31:0] m_arp_tpa;

    modport master (
        output m_frame_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type, m_arp_htype,
               m_arp_ptype, m_arp_oper, m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa,
        input  m_frame_ready
    );

    modport slave (
        input  m_frame_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type, m_arp_htype,
               m_arp_ptype, m_arp_oper, m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa,
        output m_frame_ready
    );
endinterface

// File: rtl/arp_tx_sched.sv
// Shares the ARP frame transmitter between replies and retried requests, with timeout report.
// Optional gratuitous ARP (garp_trigger port) when ARP_TX_SCHED_GRATUITOUS_EN is defined.
module arp_tx_sched #(
    parameter int unsigned RETRY_W = 4,
    parameter int unsigned TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_reply_valid,
    output logic               s_reply_ready,
    input  logic [47:0]        s_reply_tha,
    input  logic [31:0]        s_reply_tpa,
    input  logic               s_req_valid,
    output logic               s_req_ready,
    input  logic [31:0]        s_req_ip,
    input  logic               resolve_valid,
    input  logic [31:0]        resolve_ip,
    arp_tx_sched_if.master     frame,
    input  logic [47:0]        cfg_local_mac,
    input  logic [31:0]        cfg_local_ip,
    input  logic [RETRY_W-1:0] cfg_retry_count,
    input  logic [TIMER_W-1:0] cfg_retry_interval,
`ifdef ARP_TX_SCHED_GRATUITOUS_EN
    input  logic               garp_trigger,
`endif
    output logic               req_timeout,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    state_e             state_q, state_d;
    logic               pending_q, pending_d;
    logic [31:0]        pend_ip_q, pend_ip_d;
    logic [RETRY_W-1:0] retries_q, retries_d;
    logic               send_req_q, send_req_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               req_timeout_q, req_timeout_d;
    logic               reply_hold_q, reply_hold_d;
    logic               valid_q, valid_d;
    logic               req_slot_q, req_slot_d;
    logic               loaded_q, loaded_d;
    logic [47:0]        dest_q, dest_d;
    logic [47:0]        src_q, src_d;
    logic [47:0]        tha_q, tha_d;
    logic [31:0]        spa_q, spa_d;
    logic [31:0]        tpa_q, tpa_d;
    logic [1:0]         oper_q, oper_d;

    logic slot_free, handshake, resolve_hit, expire, expire_retx, want_req;
    logic reply_load, req_load, garp_load;

    assign slot_free   = !valid_q;
    assign handshake   = valid_q && frame.m_frame_ready;
    assign resolve_hit = resolve_valid && pending_q && (resolve_ip == pend_ip_q);
    assign expire      = (state_q == StWait) && (timer_q == TIMER_W'(1));
    assign expire_retx = expire && (retries_q != '0) && !resolve_hit;
    // Expiry with a free slot loads the retransmission on the expiry edge itself.
    assign want_req    = (send_req_q || expire_retx) && !resolve_hit;
    assign reply_load  = slot_free && s_reply_valid && s_reply_ready;
    assign req_load    = slot_free && !s_reply_valid && want_req;

`ifdef ARP_TX_SCHED_GRATUITOUS_EN
    logic garp_q, garp_d, garp_prev_q, garp_prev_d;

    assign garp_load   = slot_free && !s_reply_valid && !want_req && garp_q;
    assign garp_prev_d = garp_trigger;

    always_comb begin
        garp_d = garp_q;
        if (garp_load) garp_d = 1'b0;
        if (garp_trigger && !garp_prev_q) garp_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            garp_q      <= 1'b0;
            garp_prev_q <= 1'b0;
        end else begin
            garp_q      <= garp_d;
            garp_prev_q <= garp_prev_d;
        end
    end
`else
    assign garp_load = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        pend_ip_d     = pend_ip_q;
        retries_d     = retries_q;
        send_req_d    = send_req_q;
        timer_d       = (timer_q != '0) ? timer_q - TIMER_W'(1) : '0;
        req_timeout_d = 1'b0;
        reply_hold_d  = 1'b0;
        valid_d       = valid_q;
        req_slot_d    = req_slot_q;
        loaded_d      = loaded_q;
        dest_d        = dest_q;
        src_d         = src_q;
        tha_d         = tha_q;
        spa_d         = spa_q;
        tpa_d         = tpa_q;
        oper_d        = oper_q;

        if (handshake) begin
            valid_d    = 1'b0;
            req_slot_d = 1'b0;
        end

        if (reply_load || req_load || garp_load) begin
            valid_d    = 1'b1;
            loaded_d   = 1'b1;
            src_d      = cfg_local_mac;
            spa_d      = cfg_local_ip;
            req_slot_d = req_load;
        end

        if (reply_load) begin
            dest_d = s_reply_tha;
            tha_d  = s_reply_tha;
            tpa_d  = s_reply_tpa;
            oper_d = 2'd2;
        end else if (req_load) begin
            dest_d     = '1;
            tha_d      = '0;
            tpa_d      = pend_ip_q;
            oper_d     = 2'd1;
            send_req_d = 1'b0;
        end else if (garp_load) begin
            dest_d = '1;
            tha_d  = '0;
            tpa_d  = cfg_local_ip;
            oper_d = 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (s_req_valid && s_req_ready) begin
                    pending_d  = 1'b1;
                    pend_ip_d  = s_req_ip;
                    retries_d  = cfg_retry_count;
                    send_req_d = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                // Only the handshake of the frame carrying this request starts the timer.
                if (handshake && req_slot_q && !send_req_q) begin
                    timer_d = (cfg_retry_interval == '0) ? TIMER_W'(1) : cfg_retry_interval;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (expire) begin
                    if (retries_q != '0) begin
                        retries_d  = retries_q - RETRY_W'(1);
                        send_req_d = !req_load;
                        state_d    = StSend;
                    end else begin
                        req_timeout_d = 1'b1;
                        pending_d     = 1'b0;
                        state_d       = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (resolve_hit) begin
            pending_d     = 1'b0;
            send_req_d    = 1'b0;
            req_timeout_d = 1'b0;
            state_d       = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pending_q     <= 1'b0;
            pend_ip_q     <= '0;
            retries_q     <= '0;
            send_req_q    <= 1'b0;
            timer_q       <= '0;
            req_timeout_q <= 1'b0;
            reply_hold_q  <= 1'b1;
            valid_q       <= 1'b0;
            req_slot_q    <= 1'b0;
            loaded_q      <= 1'b0;
            dest_q        <= '0;
            src_q         <= '0;
            tha_q         <= '0;
            spa_q         <= '0;
            tpa_q         <= '0;
            oper_q        <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            pend_ip_q     <= pend_ip_d;
            retries_q     <= retries_d;
            send_req_q    <= send_req_d;
            timer_q       <= timer_d;
            req_timeout_q <= req_timeout_d;
            reply_hold_q  <= reply_hold_d;
            valid_q       <= valid_d;
            req_slot_q    <= req_slot_d;
            loaded_q      <= loaded_d;
            dest_q        <= dest_d;
            src_q         <= src_d;
            tha_q         <= tha_d;
            spa_q         <= spa_d;
            tpa_q         <= tpa_d;
            oper_q        <= oper_d;
        end
    end

    assign s_reply_ready = !valid_q && !reply_hold_q;
    assign s_req_ready   = !pending_q;
    assign req_timeout   = req_timeout_q;
    assign busy          = pending_q || valid_q;

    assign frame.m_frame_valid  = valid_q;
    assign frame.m_eth_dest_mac = dest_q;
    assign frame.m_eth_src_mac  = src_q;
    assign frame.m_eth_type     = loaded_q ? 16'h0806 : 16'h0000;
    assign frame.m_arp_htype    = {15'd0, loaded_q};
    assign frame.m_arp_ptype    = loaded_q ? 16'h0800 : 16'h0000;
    assign frame.m_arp_oper     = {14'd0, oper_q};
    assign frame.m_arp_sha      = src_q;
    assign frame.m_arp_spa      = spa_q;
    assign frame.m_arp_tha      = tha_q;
    assign frame.m_arp_tpa      = tpa_q;

endmodule

// File: tb/tb_arp_tx_sched.sv
// Directed and randomized checks of arp_tx_sched against a frame-log reference model.
module tb_arp_tx_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_reply_valid = 1'b0;
    logic        s_reply_ready;
    logic [47:0] s_reply_tha = '0;
    logic [31:0] s_reply_tpa = '0;
    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic [31:0] s_req_ip = '0;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_ip = '0;
    logic [47:0] cfg_local_mac = 48'h0A0B0C0D0E0F;
    logic [31:0] cfg_local_ip = 32'hC0A80001;
    logic [3:0]  cfg_retry_count = '0;
    logic [31:0] cfg_retry_interval = 32'd10;
    logic        req_timeout;
    logic        busy;
`ifdef ARP_TX_SCHED_GRATUITOUS_EN
    logic        garp_trigger = 1'b0;
`endif

    always #5 clk = ~clk;

    arp_tx_sched_if f ();

    arp_tx_sched #(.RETRY_W(4), .TIMER_W(32)) dut (
        .clk(clk), .rst(rst),
        .s_reply_valid(s_reply_valid), .s_reply_ready(s_reply_ready),
        .s_reply_tha(s_reply_tha), .s_reply_tpa(s_reply_tpa),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_ip(s_req_ip),
        .resolve_valid(resolve_valid), .resolve_ip(resolve_ip),
        .frame(f),
        .cfg_local_mac(cfg_local_mac), .cfg_local_ip(cfg_local_ip),
        .cfg_retry_count(cfg_retry_count), .cfg_retry_interval(cfg_retry_interval),
`ifdef ARP_TX_SCHED_GRATUITOUS_EN
        .garp_trigger(garp_trigger),
`endif
        .req_timeout(req_timeout), .busy(busy)
    );

    typedef struct {
        int          cyc;
        logic [15:0] oper;
        logic [47:0] dest;
        logic [47:0] tha;
        logic [31:0] tpa;
    } frm_t;

    frm_t frames[$];
    int   touts[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every frame handshake (stamped with its edge) and every timeout pulse.
    always @(negedge clk) begin
        frm_t e;
        if (!rst && f.m_frame_valid && f.m_frame_ready) begin
            e.cyc  = cyc + 1;
            e.oper = f.m_arp_oper;
            e.dest = f.m_eth_dest_mac;
            e.tha  = f.m_arp_tha;
            e.tpa  = f.m_arp_tpa;
            frames.push_back(e);
        end
        if (req_timeout) touts.push_back(cyc);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && frames.size() < n; i++) tick();
        chk(tag, 64'(frames.size() >= n), 64'd1);
    endtask

    task automatic wait_tout(input int budget, input string tag);
        for (int i = 0; i < budget && touts.size() == 0; i++) tick();
        chk(tag, 64'(touts.size()), 64'd1);
    endtask

    task automatic issue_req(input logic [31:0] ip);
        s_req_valid = 1'b1;
        s_req_ip    = ip;
        tick();
        s_req_valid = 1'b0;
    endtask

    task automatic clear_logs();
        frames.delete();
        touts.delete();
    endtask

    frm_t        exp_q[$];
    int          reqc[$];
    int          rc, iv, ri, h;
    logic [31:0] rip;
    logic        acc, stable;

    initial begin
        f.m_frame_ready = 1'b1;
        tick(3);
        chk("rst_valid", f.m_frame_valid, 0);
        chk("rst_oper", f.m_arp_oper, 0);
        chk("rst_eth_type", f.m_eth_type, 0);
        chk("rst_dest", f.m_eth_dest_mac, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", req_timeout, 0);
        rst = 1'b0;
        tick(2);

        // 1: single reply frame, latency 1
        clear_logs();
        s_reply_valid = 1'b1;
        s_reply_tha   = 48'h020000000001;
        s_reply_tpa   = 32'h0A000005;
        chk("t1_reply_ready", s_reply_ready, 1);
        tick();
        s_reply_valid = 1'b0;
        chk("t1_valid", f.m_frame_valid, 1);
        chk("t1_oper", f.m_arp_oper, 2);
        chk("t1_dest", f.m_eth_dest_mac, 48'h020000000001);
        chk("t1_tha", f.m_arp_tha, 48'h020000000001);
        chk("t1_tpa", f.m_arp_tpa, 32'h0A000005);
        chk("t1_sha", f.m_arp_sha, cfg_local_mac);
        chk("t1_spa", f.m_arp_spa, cfg_local_ip);
        chk("t1_fixed", {f.m_eth_type, f.m_arp_htype, f.m_arp_ptype}, 48'h080600010800);
        tick();
        chk("t1_done", f.m_frame_valid, 0);
        chk("t1_count", frames.size(), 1);

        // 2: three requests, then timeout
        clear_logs();
        cfg_retry_count    = 4'd2;
        cfg_retry_interval = 32'd100;
        chk("t2_req_ready", s_req_ready, 1);
        issue_req(32'h0A000009);
        chk("t2_req_busy", {s_req_ready, busy}, 2'b01);
        tick();
        chk("t2_req_frame", {f.m_frame_valid, f.m_arp_oper}, {1'b1, 16'd1});
        chk("t2_bcast", f.m_eth_dest_mac, 48'hFFFFFFFFFFFF);
        chk("t2_tha", f.m_arp_tha, 0);
        chk("t2_tpa", f.m_arp_tpa, 32'h0A000009);
        wait_tout(500, "t2_timeout_seen");
        chk("t2_ready_after", {s_req_ready, busy}, 2'b10);
        chk("t2_nframes", frames.size(), 3);
        if (frames.size() == 3 && touts.size() == 1) begin
            chk("t2_gap1", frames[1].cyc - frames[0].cyc, 101);
            chk("t2_gap2", frames[2].cyc - frames[1].cyc, 101);
            chk("t2_tout_delay", touts[0] - frames[2].cyc, 100);
        end
        tick(3);
        chk("t2_single_pulse", touts.size(), 1);

        // 3: non-matching resolve ignored, matching resolve clears
        clear_logs();
        cfg_retry_count    = 4'd3;
        cfg_retry_interval = 32'd50;
        issue_req(32'h0A000009);
        wait_frames(1, 20, "t3_first_sent");
        tick(10);
        resolve_valid = 1'b1;
        resolve_ip    = 32'h0A000008;
        tick();
        resolve_valid = 1'b0;
        chk("t3_nomatch", s_req_ready, 0);
        tick();
        resolve_valid = 1'b1;
        resolve_ip    = 32'h0A000009;
        tick();
        resolve_valid = 1'b0;
        chk("t3_ready_next", s_req_ready, 1);
        tick(200);
        chk("t3_no_more", frames.size(), 1);
        chk("t3_no_tout", touts.size(), 0);
        chk("t3_idle", busy, 0);

        // 4: reply wins, held stable under backpressure, request follows after gap
        clear_logs();
        cfg_retry_count    = 4'd0;
        cfg_retry_interval = 32'd20;
        f.m_frame_ready    = 1'b0;
        s_reply_valid      = 1'b1;
        s_reply_tha        = 48'h020000000002;
        s_reply_tpa        = 32'h0A000006;
        s_req_valid        = 1'b1;
        s_req_ip           = 32'h0A00000A;
        tick();
        s_reply_valid = 1'b0;
        s_req_valid   = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stable &= (f.m_frame_valid === 1'b1) && (f.m_arp_oper === 16'd2)
                    && (f.m_eth_dest_mac === 48'h020000000002) && (f.m_arp_tpa === 32'h0A000006);
            tick();
        end
        chk("t4_hold_stable", stable, 1);
        f.m_frame_ready = 1'b1;
        tick();
        chk("t4_gap", f.m_frame_valid, 0);
        tick();
        chk("t4_req_follows", {f.m_frame_valid, f.m_arp_oper}, {1'b1, 16'd1});
        chk("t4_req_tpa", f.m_arp_tpa, 32'h0A00000A);
        wait_tout(100, "t4_timeout_seen");
        if (frames.size() == 2 && touts.size() == 1)
            chk("t4_tout_delay", touts[0] - frames[1].cyc, 20);
        else
            chk("t4_nframes", frames.size(), 2);

        // 5: resolve on the expiry edge wins
        clear_logs();
        cfg_retry_count    = 4'd1;
        cfg_retry_interval = 32'd10;
        issue_req(32'h0A00000B);
        wait_frames(1, 20, "t5_first_sent");
        h = (frames.size() > 0) ? frames[0].cyc : cyc;
        for (int i = 0; i < 20 && cyc < h + 9; i++) tick();
        resolve_valid = 1'b1;
        resolve_ip    = 32'h0A00000B;
        tick();
        resolve_valid = 1'b0;
        tick(50);
        chk("t5_no_retx", frames.size(), 1);
        chk("t5_no_tout", touts.size(), 0);
        chk("t5_ready", s_req_ready, 1);

        // Reset while a frame is held drops it
        f.m_frame_ready = 1'b0;
        s_reply_valid   = 1'b1;
        tick();
        s_reply_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", f.m_frame_valid, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        f.m_frame_ready = 1'b1;
        tick(2);

`ifdef ARP_TX_SCHED_GRATUITOUS_EN
        // 6: coalesced gratuitous triggers
        clear_logs();
        f.m_frame_ready = 1'b0;
        s_reply_valid   = 1'b1;
        tick();
        s_reply_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            garp_trigger = 1'b1;
            tick();
            garp_trigger = 1'b0;
            tick();
        end
        f.m_frame_ready = 1'b1;
        tick(8);
        chk("t6_nframes", frames.size(), 2);
        if (frames.size() == 2) begin
            chk("t6_oper", frames[1].oper, 1);
            chk("t6_tpa", frames[1].tpa, cfg_local_ip);
            chk("t6_dest", frames[1].dest, 48'hFFFFFFFFFFFF);
        end
`endif

        // Random: reply traffic with random backpressure around one request lifecycle
        for (int it = 0; it < 4; it++) begin
            rc  = $urandom_range(0, 3);
            iv  = $urandom_range(3, 15);
            rip = $urandom;
            cfg_retry_count    = 4'(rc);
            cfg_retry_interval = 32'(iv);
            clear_logs();
            exp_q.delete();
            reqc.delete();
            issue_req(rip);
            for (int c = 0; c < 3000 && touts.size() == 0; c++) begin
                f.m_frame_ready = ($urandom_range(0, 3) != 0);
                if (!s_reply_valid && $urandom_range(0, 5) == 0) begin
                    s_reply_valid = 1'b1;
                    s_reply_tha   = {16'h0200, 32'($urandom)};
                    s_reply_tpa   = $urandom;
                end
                acc = s_reply_valid && s_reply_ready;
                tick();
                if (acc) begin
                    exp_q.push_back('{cyc: 0, oper: 16'd2, dest: s_reply_tha,
                                      tha: s_reply_tha, tpa: s_reply_tpa});
                    s_reply_valid = 1'b0;
                end
            end
            s_reply_valid   = 1'b0;
            f.m_frame_ready = 1'b1;
            tick(6);
            chk("rnd_tout_count", touts.size(), 1);
            ri = 0;
            foreach (frames[k]) begin
                if (frames[k].oper == 16'd2) begin
                    if (ri < exp_q.size()) begin
                        chk("rnd_reply_tha", frames[k].tha, exp_q[ri].tha);
                        chk("rnd_reply_tpa", frames[k].tpa, exp_q[ri].tpa);
                    end
                    ri++;
                end else begin
                    chk("rnd_req_tpa", frames[k].tpa, rip);
                    reqc.push_back(frames[k].cyc);
                end
            end
            chk("rnd_reply_count", ri, exp_q.size());
            chk("rnd_req_count", reqc.size(), rc + 1);
            for (int k = 1; k < reqc.size(); k++)
                chk("rnd_req_spacing", 64'(reqc[k] - reqc[k-1] >= iv + 1), 64'd1);
            if (reqc.size() > 0 && touts.size() > 0)
                chk("rnd_tout_delay", touts[0] - reqc[reqc.size()-1], iv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
